bcd_to_binary: RTL and testbench

Sequential converter from four packed BCD digits (thousands, hundreds, tens, units) to a 16-bit unsigned binary value. It runs a Horner multiply-by-ten accumulation, one digit per clock, with a start/busy/done handshake. It sits between the digit-entry path (keypad or digit registers) and arithmetic logic that needs native binary operands. It is the inverse of the binary-to-BCD subsystem feeding the 7-segment display.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_mul10_sum.sv | 23 ++
 rtl/bcd_to_binary.sv | 139 +++++++++++++
 tb/tb_bcd_to_binary.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared constants and types for the BCD <-> binary conversion blocks.
// Holds the converter state encoding, the fixed digit count and binary
// width, and a small digit-validity helper.
package bcd_pkg;

  localparam int         NUM_DIGITOS = 4;
  localparam int         ANCHO_BIN   = 16;
  localparam logic [3:0] MAX_DIGITO  = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    ACUM = 1'b1
  } estado_t;

  // A BCD digit is legal only in the range 0..9.
  function automatic logic digito_invalido(input logic [3:0] d);
    return d > MAX_DIGITO;
  endfunction

endpackage

// File: rtl/bcd_mul10_sum.sv
// bcd_mul10_sum
// Combinational Horner step: resultado = acc*10 + digito.
// Ports:
//   acc       in  16  running accumulator
//   digito    in  4   BCD digit to add (zero-extended)
//   resultado out 16  acc*10 + digito, truncated to 16 bits
module bcd_mul10_sum
  import bcd_pkg::*;
(
  input  logic [ANCHO_BIN-1:0] acc,
  input  logic [3:0]           digito,
  output logic [ANCHO_BIN-1:0] resultado
);

  logic [ANCHO_BIN-1:0] por_diez;

  // acc*10 = acc*8 + acc*2. Truncating the 17-bit sum to 16 bits is the
  // same as adding modulo 2^16, so the shifts are kept at 16 bits. With
  // four legal digits the value never exceeds 9999, so nothing is lost.
  assign por_diez  = (acc << 3) + (acc << 1);
  assign resultado = por_diez + {{(ANCHO_BIN-4){1'b0}}, digito};

endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
// Sequential four-digit packed BCD to 16-bit binary converter. One digit is
// folded in per clock (thousands first) with a Horner multiply-by-ten.
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   conversion request, sampled only while idle
//   millares_input in 4 thousands digit
//   centenas_input in 4 hundreds digit
//   decenas_input  in 4 tens digit
//   unidades_input in 4 units digit
//   numero_output  out 16 last result, held until the next completion
//   ocupado        out  high while a conversion is in progress
//   listo          out  one-cycle completion pulse (result valid)
//   error          out  last accepted request had a digit > 9
module bcd_to_binary
  import bcd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           millares_input,
  input  logic [3:0]           centenas_input,
  input  logic [3:0]           decenas_input,
  input  logic [3:0]           unidades_input,
  output logic [ANCHO_BIN-1:0] numero_output,
  output logic                 ocupado,
  output logic                 listo,
  output logic                 error
);

  estado_t                           estado_q, estado_d;
  logic [ANCHO_BIN-1:0]              acc_q, acc_d;
  logic [1:0]                        idx_q, idx_d;
  logic [NUM_DIGITOS-1:0][3:0]       digitos_q, digitos_d;
  logic [ANCHO_BIN-1:0]              numero_q, numero_d;
  logic                              listo_q, listo_d;
  logic                              error_q, error_d;

  // Element 0 is the thousands digit so idx walks in Horner order.
  logic [NUM_DIGITOS-1:0][3:0]       entrada;
  logic [NUM_DIGITOS-1:0]            digito_malo;
  logic                              hay_malo;
  logic [3:0]                        digito_sel;
  logic [ANCHO_BIN-1:0]              suma;

  assign entrada = {unidades_input, decenas_input, centenas_input, millares_input};

  // Validity is judged on the live inputs, since the decision is taken on
  // the same edge that captures them.
  for (genvar gi = 0; gi < NUM_DIGITOS; gi++) begin : g_valida
    assign digito_malo[gi] = digito_invalido(entrada[gi]);
  end
  assign hay_malo = |digito_malo;

  assign digito_sel = digitos_q[idx_q];

  bcd_mul10_sum u_mul10_sum (
    .acc       (acc_q),
    .digito    (digito_sel),
    .resultado (suma)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      digitos_q <= '0;
      numero_q  <= '0;
      listo_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      digitos_q <= digitos_d;
      numero_q  <= numero_d;
      listo_q   <= listo_d;
      error_q   <= error_d;
    end
  end

  // Next-state logic. An invalid request never leaves IDLE.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE:    if (start && !hay_malo) estado_d = ACUM;
      ACUM:    if (idx_q == 2'd3)      estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  // Datapath updates. listo defaults low so it only ever lasts one cycle
  // per accepted request or completed conversion.
  always_comb begin
    acc_d     = acc_q;
    idx_d     = idx_q;
    digitos_d = digitos_q;
    numero_d  = numero_q;
    listo_d   = 1'b0;
    error_d   = error_q;
    case (estado_q)
      IDLE: begin
        if (start) begin
          digitos_d = entrada;
          if (hay_malo) begin
            numero_d = '0;
            error_d  = 1'b1;
            listo_d  = 1'b1;
          end else begin
            acc_d   = '0;
            idx_d   = 2'd0;
            error_d = 1'b0;
          end
        end
      end
      ACUM: begin
        acc_d = suma;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          numero_d = suma;
          listo_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    ocupado       = (estado_q != IDLE);
    numero_output = numero_q;
    listo         = listo_q;
    error         = error_q;
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  millares_input = '0;
  logic [3:0]  centenas_input = '0;
  logic [3:0]  decenas_input  = '0;
  logic [3:0]  unidades_input = '0;
  logic [15:0] numero_output;
  logic        ocupado;
  logic        listo;
  logic        error;

  typedef struct {
    logic [15:0] num;
    logic        err;
    int          due;  // cycle at which listo must be seen; -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bcd_to_binary dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .millares_input (millares_input),
    .centenas_input (centenas_input),
    .decenas_input  (decenas_input),
    .unidades_input (unidades_input),
    .numero_output  (numero_output),
    .ocupado        (ocupado),
    .listo          (listo),
    .error          (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_digits(input logic [3:0] m, input logic [3:0] c,
                            input logic [3:0] d, input logic [3:0] u);
    millares_input = m;
    centenas_input = c;
    decenas_input  = d;
    unidades_input = u;
  endtask

  task automatic push_exp(input logic [15:0] num, input logic err, input int due);
    exp_t e;
    e.num = num;
    e.err = err;
    e.due = due;
    exp_q.push_back(e);
  endtask

  // Returns on a negedge where listo is high (current one included).
  task automatic wait_listo();
    int n = 0;
    while (!listo && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("wait_listo", {31'd0, listo}, 32'd1);
  endtask

  // One start pulse; start accepted at the next posedge (cyc+1).
  task automatic do_conv(input logic [3:0] m, input logic [3:0] c,
                         input logic [3:0] d, input logic [3:0] u,
                         input logic [15:0] exp_num, input logic exp_err);
    @(negedge clk);
    set_digits(m, c, d, u);
    start = 1'b1;
    push_exp(exp_num, exp_err, exp_err ? cyc + 1 : cyc + 5);
    @(negedge clk);
    start = 1'b0;
    check("ocupado_after_accept", {31'd0, ocupado}, {31'd0, !exp_err});
    if (!exp_err) begin
      for (int i = 1; i < 4; i++) begin
        @(negedge clk);
        check("ocupado_during_acum", {31'd0, ocupado}, 32'd1);
      end
    end
    wait_listo();
    $display("conv digits %0d,%0d,%0d,%0d -> expect 0x%04h err=%0d", m, c, d, u, exp_num, exp_err);
  endtask

  initial begin
    fork
      // Monitor: pops one expectation per listo pulse.
      begin
        forever begin
          @(negedge clk);
          if (!rst && listo) begin
            if (exp_q.size() == 0) begin
              check("unexpected_listo", {31'd0, listo}, 32'd0);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              $display("listo at cycle %0d: numero=0x%04h error=%0d ocupado=%0d",
                       cyc, numero_output, error, ocupado);
              check("numero_output", {16'd0, numero_output}, {16'd0, e.num});
              check("error", {31'd0, error}, {31'd0, e.err});
              check("ocupado_at_listo", {31'd0, ocupado}, 32'd0);
              if (e.due >= 0) check("listo_cycle", cyc, e.due);
            end
          end
        end
      end
      // Stimulus
      begin
        repeat (2) @(negedge clk);
        check("reset_numero", {16'd0, numero_output}, 32'd0);
        check("reset_ocupado", {31'd0, ocupado}, 32'd0);
        check("reset_listo", {31'd0, listo}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        rst = 1'b0;

        do_conv(4'd1, 4'd2, 4'd3, 4'd4, 16'h04D2, 1'b0);
        do_conv(4'd9, 4'd9, 4'd9, 4'd9, 16'h270F, 1'b0);
        do_conv(4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0);

        // Invalid digit: immediate listo+error, never busy, error held.
        do_conv(4'd1, 4'hA, 4'd0, 4'd0, 16'h0000, 1'b1);
        @(negedge clk);
        check("invalid_listo_drops", {31'd0, listo}, 32'd0);
        check("invalid_no_ocupado", {31'd0, ocupado}, 32'd0);
        check("invalid_error_held", {31'd0, error}, 32'd1);
        do_conv(4'd0, 4'd0, 4'd4, 4'd2, 16'h002A, 1'b0);

        // Start re-pulsed and digits changed mid-conversion: ignored.
        @(negedge clk);
        set_digits(4'd3, 4'd0, 4'd0, 4'd7);
        start = 1'b1;
        push_exp(16'h0BBF, 1'b0, cyc + 5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        set_digits(4'd9, 4'd9, 4'd9, 4'd9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_listo();
        $display("conv digits 3,0,0,7 with mid-flight changes -> expect 0x0BBF");

        // Reset during the second ACUM cycle abandons the conversion.
        @(negedge clk);
        set_digits(4'd7, 4'd7, 4'd7, 4'd7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_numero", {16'd0, numero_output}, 32'd0);
        check("rst_ocupado", {31'd0, ocupado}, 32'd0);
        check("rst_listo", {31'd0, listo}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_idle_ocupado", {31'd0, ocupado}, 32'd0);
        $display("reset mid-conversion applied; no listo expected");
        do_conv(4'd5, 4'd0, 4'd0, 4'd0, 16'h1388, 1'b0);

        // start held high: back-to-back conversions, stop after four.
        @(negedge clk);
        set_digits(4'd0, 4'd1, 4'd0, 4'd0);
        start = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(16'h0064, 1'b0, -1);
        begin
          int seen = 0;
          int n = 0;
          while (seen < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (listo) seen++;
          end
          start = 1'b0;
          check("held_start_pulses", seen, 4);
        end
        $display("held start: four conversions of 0,1,0,0 -> 0x0064");
        repeat (12) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
